// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-master round-robin arbiter for one memory port, with watchdog | rev 1.0
`default_nettype none

module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic [1:0]  m0_wd_unit,
  input  logic [1:0]  m0_rd_unit,
  output logic        m0_done,
  output logic [31:0] m0_rd,
  output logic        m0_fault,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic [1:0]  m1_wd_unit,
  input  logic [1:0]  m1_rd_unit,
  output logic        m1_done,
  output logic [31:0] m1_rd,
  output logic        m1_fault,

  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [1:0]  mem_wd_unit,
  output logic [1:0]  mem_rd_unit,
  input  logic [31:0] mem_rd,
  input  logic        mem_ready,
  input  logic        access_fault,

  output logic        busy,
  output logic        owner
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             prio;
  logic [CNT_W-1:0] count;

  logic        req_any;
  logic        grant;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wd;
  logic [1:0]  win_wd_unit;
  logic [1:0]  win_rd_unit;
  logic [31:0] rd_next;

  // A lone requester wins outright; a tie goes to the master named by prio.
  always_comb begin
    req_any     = m0_req | m1_req;
    grant       = (m0_req & m1_req) ? prio : m1_req;
    win_we      = grant ? m1_we      : m0_we;
    win_addr    = grant ? m1_addr    : m0_addr;
    win_wd      = grant ? m1_wd      : m0_wd;
    win_wd_unit = grant ? m1_wd_unit : m0_wd_unit;
    win_rd_unit = grant ? m1_rd_unit : m0_rd_unit;
    rd_next     = mem_re ? mem_rd : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prio        <= 1'b0;
      owner       <= 1'b0;
      busy        <= 1'b0;
      count       <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wd      <= 32'h0;
      mem_wd_unit <= 2'b00;
      mem_rd_unit <= 2'b00;
      m0_done     <= 1'b0;
      m0_rd       <= 32'h0;
      m0_fault    <= 1'b0;
      m1_done     <= 1'b0;
      m1_rd       <= 32'h0;
      m1_fault    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            owner       <= grant;
            prio        <= ~grant;
            count       <= '0;
            busy        <= 1'b1;
            mem_re      <= ~win_we;
            mem_we      <= win_we;
            mem_addr    <= win_addr;
            mem_wd      <= win_wd;
            mem_wd_unit <= win_wd_unit;
            mem_rd_unit <= win_rd_unit;
            state       <= BUSY;
          end
        end

        BUSY: begin
          if (mem_ready) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (owner) begin
              m1_done  <= 1'b1;
              m1_rd    <= rd_next;
              m1_fault <= access_fault;
            end else begin
              m0_done  <= 1'b1;
              m0_rd    <= rd_next;
              m0_fault <= access_fault;
            end
            state <= DONE;
          end else if (count == CNT_LAST) begin
            // Watchdog expiry: complete the hung access as a fault with no data.
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (owner) begin
              m1_done  <= 1'b1;
              m1_rd    <= 32'h0;
              m1_fault <= 1'b1;
            end else begin
              m0_done  <= 1'b1;
              m0_rd    <= 32'h0;
              m0_fault <= 1'b1;
            end
            state <= DONE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end

        DONE: begin
          m0_done  <= 1'b0;
          m0_rd    <= 32'h0;
          m0_fault <= 1'b0;
          m1_done  <= 1'b0;
          m1_rd    <= 32'h0;
          m1_fault <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter (TIMEOUT=16).
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic [1:0]  m0_wd_unit, m0_rd_unit, m1_wd_unit, m1_rd_unit;
  logic        m0_done, m0_fault, m1_done, m1_fault;
  logic [31:0] m0_rd, m1_rd;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [1:0]  mem_wd_unit, mem_rd_unit;
  logic        mem_ready, access_fault;
  logic        busy, owner;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_wd_unit(m0_wd_unit), .m0_rd_unit(m0_rd_unit),
    .m0_done(m0_done), .m0_rd(m0_rd), .m0_fault(m0_fault),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_wd_unit(m1_wd_unit), .m1_rd_unit(m1_rd_unit),
    .m1_done(m1_done), .m1_rd(m1_rd), .m1_fault(m1_fault),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_wd_unit(mem_wd_unit), .mem_rd_unit(mem_rd_unit),
    .mem_rd(mem_rd), .mem_ready(mem_ready), .access_fault(access_fault),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Results of the most recent run_txn call.
  int          re_cnt, we_cnt, d0, d1, bad, done_cyc;
  logic [31:0] rd_got, addr_got, wd_got;
  logic [1:0]  wdu_got, rdu_got;
  logic        f_got, own_got;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0; m0_wd_unit = 0; m0_rd_unit = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0; m1_wd_unit = 0; m1_rd_unit = 0;
    mem_rd = 0; mem_ready = 0; access_fault = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Slave model plus observer: mem_ready rises once the access has been
  // active for lat cycles (lat=0 never answers). Returns after the first done.
  task automatic run_txn(input int max_cyc, input int lat, input logic flt, input bit drop);
    int act;
    act = 0; re_cnt = 0; we_cnt = 0; d0 = 0; d1 = 0; bad = 0; done_cyc = -100;
    rd_got = 'x; f_got = 'x; own_got = 'x;
    addr_got = 'x; wd_got = 'x; wdu_got = 'x; rdu_got = 'x;
    for (int c = 0; c < max_cyc; c++) begin
      tick();
      if (mem_re) re_cnt++;
      if (mem_we) we_cnt++;
      if (mem_re || mem_we) begin
        if (act == 0) begin
          addr_got = mem_addr; wd_got = mem_wd;
          wdu_got = mem_wd_unit; rdu_got = mem_rd_unit;
        end
        act++;
      end
      if (m0_done && m1_done) bad++;
      if (!m0_done && (m0_rd != 0 || m0_fault)) bad++;
      if (!m1_done && (m1_rd != 0 || m1_fault)) bad++;
      if (m0_done || m1_done) begin
        if (m0_done) d0++;
        if (m1_done) d1++;
        rd_got   = m0_done ? m0_rd : m1_rd;
        f_got    = m0_done ? m0_fault : m1_fault;
        own_got  = owner;
        done_cyc = cyc;
        if (drop) begin
          if (m0_done) m0_req = 0;
          else         m1_req = 0;
        end
        mem_ready = 0;
        access_fault = 0;
        break;
      end
      mem_ready    = (lat != 0) && (mem_re || mem_we) && (act >= lat);
      access_fault = mem_ready & flt;
    end
  endtask

  task automatic test_reset;
    clear_inputs();
    m0_req = 1; m1_req = 1;
    reset = 1;
    tick();
    tick();
    checks++;
    if ({mem_re, mem_we, busy, owner, m0_done, m1_done, m0_fault, m1_fault} !== 8'h00) begin
      fails++;
      $display("FAIL reset_flags: got %b, expected 00000000",
               {mem_re, mem_we, busy, owner, m0_done, m1_done, m0_fault, m1_fault});
    end
    checks++;
    if ({mem_addr, mem_wd, m0_rd, m1_rd, mem_wd_unit, mem_rd_unit} !== 132'h0) begin
      fails++;
      $display("FAIL reset_data: got addr=%h wd=%h rd0=%h rd1=%h, expected all 0",
               mem_addr, mem_wd, m0_rd, m1_rd);
    end
    clear_inputs();
    reset = 0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_req_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_single_read;
    do_reset();
    mem_rd = 32'hDEADBEEF;
    m0_addr = 32'h100; m0_rd_unit = 2'b10; m0_req = 1;
    run_txn(20, 2, 1'b0, 1'b1);
    checks++;
    if (d0 !== 1 || d1 !== 0) begin
      fails++; $display("FAIL rd_done_count: got d0=%0d d1=%0d, expected 1 0", d0, d1);
    end
    checks++;
    if (re_cnt !== 2 || we_cnt !== 0) begin
      fails++; $display("FAIL rd_re_cycles: got re=%0d we=%0d, expected 2 0", re_cnt, we_cnt);
    end
    checks++;
    if (rd_got !== 32'hDEADBEEF || f_got !== 1'b0) begin
      fails++; $display("FAIL rd_data: got %h fault=%b, expected deadbeef fault=0", rd_got, f_got);
    end
    checks++;
    if (addr_got !== 32'h100 || rdu_got !== 2'b10 || own_got !== 1'b0) begin
      fails++;
      $display("FAIL rd_port: got addr=%h rdu=%b owner=%b, expected 100 10 0", addr_got, rdu_got, own_got);
    end
    checks++;
    if (bad !== 0) begin
      fails++; $display("FAIL rd_nonowner_quiet: got %0d violations, expected 0", bad);
    end
    tick();
    checks++;
    if ({m0_done, m0_fault, busy} !== 3'b000 || m0_rd !== 32'h0) begin
      fails++;
      $display("FAIL rd_after_done: got done=%b fault=%b busy=%b rd=%h, expected all 0",
               m0_done, m0_fault, busy, m0_rd);
    end
  endtask

  task automatic test_round_robin;
    int prev;
    logic exp_own;
    do_reset();
    mem_rd = 32'h0BADF00D;
    m0_addr = 32'h10; m1_addr = 32'h20;
    m0_req = 1; m1_req = 1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      exp_own = (i % 2 == 1);
      run_txn(20, 1, 1'b0, 1'b0);
      checks++;
      if (own_got !== exp_own || (exp_own ? d1 : d0) !== 1 || d0 + d1 !== 1) begin
        fails++;
        $display("FAIL rr_grant_%0d: got owner=%b d0=%0d d1=%0d, expected owner=%b", i, own_got, d0, d1, exp_own);
      end
      checks++;
      if (addr_got !== (exp_own ? 32'h20 : 32'h10) || rd_got !== 32'h0BADF00D) begin
        fails++;
        $display("FAIL rr_addr_%0d: got addr=%h rd=%h, expected addr=%h rd=0badf00d", i, addr_got, rd_got,
                 exp_own ? 32'h20 : 32'h10);
      end
      if (i > 0) begin
        checks++;
        if (done_cyc - prev !== 3) begin
          fails++; $display("FAIL rr_period_%0d: got %0d cycles, expected 3", i, done_cyc - prev);
        end
      end
      prev = done_cyc;
    end
    clear_inputs();
  endtask

  task automatic test_write;
    do_reset();
    mem_rd = 32'h55555555;
    m0_addr = 32'hFFFF0000; m0_wd_unit = 2'b10;
    m1_we = 1; m1_addr = 32'h2003; m1_wd = 32'h000000AB; m1_wd_unit = 2'b00; m1_rd_unit = 2'b01;
    m1_req = 1;
    run_txn(20, 1, 1'b0, 1'b1);
    checks++;
    if (we_cnt !== 1 || re_cnt !== 0) begin
      fails++; $display("FAIL wr_strobes: got we=%0d re=%0d, expected 1 0", we_cnt, re_cnt);
    end
    checks++;
    if (addr_got !== 32'h2003 || wd_got !== 32'hAB || wdu_got !== 2'b00 || rdu_got !== 2'b01) begin
      fails++;
      $display("FAIL wr_port: got addr=%h wd=%h wdu=%b rdu=%b, expected 2003 ab 00 01",
               addr_got, wd_got, wdu_got, rdu_got);
    end
    checks++;
    if (d1 !== 1 || d0 !== 0 || own_got !== 1'b1) begin
      fails++; $display("FAIL wr_done: got d0=%0d d1=%0d owner=%b, expected 0 1 1", d0, d1, own_got);
    end
    checks++;
    if (rd_got !== 32'h0 || f_got !== 1'b0 || bad !== 0) begin
      fails++; $display("FAIL wr_result: got rd=%h fault=%b bad=%0d, expected 0 0 0", rd_got, f_got, bad);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    mem_rd = 32'hCAFEF00D;
    m0_addr = 32'h300; m0_req = 1;
    run_txn(40, 0, 1'b0, 1'b1);
    checks++;
    if (re_cnt !== 16) begin
      fails++; $display("FAIL to_re_cycles: got %0d, expected 16", re_cnt);
    end
    checks++;
    if (d0 !== 1 || f_got !== 1'b1 || rd_got !== 32'h0 || bad !== 0) begin
      fails++;
      $display("FAIL to_result: got d0=%0d fault=%b rd=%h bad=%0d, expected 1 1 0 0", d0, f_got, rd_got, bad);
    end
  endtask

  task automatic test_access_fault;
    do_reset();
    mem_rd = 32'h12345678;
    m0_addr = 32'h400; m0_req = 1;
    run_txn(20, 1, 1'b1, 1'b1);
    checks++;
    if (d0 !== 1 || f_got !== 1'b1 || rd_got !== 32'h12345678) begin
      fails++;
      $display("FAIL af_result: got d0=%0d fault=%b rd=%h, expected 1 1 12345678", d0, f_got, rd_got);
    end
    mem_rd = 32'h87654321;
    m1_addr = 32'h500;
    m0_req = 1; m1_req = 1;
    run_txn(20, 1, 1'b0, 1'b1);
    checks++;
    if (own_got !== 1'b1 || d1 !== 1 || f_got !== 1'b0 || rd_got !== 32'h87654321) begin
      fails++;
      $display("FAIL af_next: got owner=%b d1=%0d fault=%b rd=%h, expected 1 1 0 87654321",
               own_got, d1, f_got, rd_got);
    end
    clear_inputs();
  endtask

  task automatic test_reset_busy;
    int dn;
    do_reset();
    m0_addr = 32'h600; m0_req = 1;
    run_txn(20, 1, 1'b0, 1'b1);
    m0_req = 1;
    tick();
    tick();
    tick();
    checks++;
    if (mem_re !== 1'b1 || busy !== 1'b1 || owner !== 1'b0) begin
      fails++; $display("FAIL rb_inflight: got re=%b busy=%b owner=%b, expected 1 1 0", mem_re, busy, owner);
    end
    reset = 1;
    mem_ready = 1;
    tick();
    checks++;
    if ({mem_re, mem_we, busy, m0_done} !== 4'b0000) begin
      fails++;
      $display("FAIL rb_abandon: got re=%b we=%b busy=%b done=%b, expected 0000", mem_re, mem_we, busy, m0_done);
    end
    reset = 0;
    clear_inputs();
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m0_done || m1_done) dn++;
    end
    checks++;
    if (dn !== 0) begin
      fails++; $display("FAIL rb_no_done: got %0d done pulses, expected 0", dn);
    end
    m0_addr = 32'h700; m1_addr = 32'h800;
    m0_req = 1; m1_req = 1;
    run_txn(20, 1, 1'b0, 1'b1);
    checks++;
    if (own_got !== 1'b0 || d0 !== 1 || addr_got !== 32'h700) begin
      fails++;
      $display("FAIL rb_prio_reset: got owner=%b d0=%0d addr=%h, expected 0 1 700", own_got, d0, addr_got);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_access_fault();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures so far", checks, fails);
    $fatal(1);
  end

endmodule

`default_nettype wire
